// File: rtl/lemmings_world_pkg.sv
// rtl/lemmings_world_pkg.sv - shared defaults, position types and behaviour decode
// Package lemmings_pkg: default level geometry and timing, lemming position
// typedefs, the behaviour enum and the priority decoder that turns the
// lemming FSM outputs into one behaviour.
package lemmings_pkg;

  localparam int LEM_W     = 16;
  localparam int LEM_D     = 8;
  localparam int LEM_STEP  = 4;
  localparam int LEM_DIG   = 8;
  localparam int LEM_FATAL = 4;

  typedef logic [$clog2(LEM_W)-1:0] lem_x_t;
  typedef logic [$clog2(LEM_D)-1:0] lem_y_t;

  typedef enum logic [2:0] {IDLE, WALK_L, WALK_R, FALL, DIG} behav_t;

  // Priority aaah > digging > walk_left > walk_right; nothing set is idle.
  function automatic behav_t decode_behav(input logic aaah, input logic digging,
                                          input logic walk_left, input logic walk_right);
    if (aaah)            return FALL;
    else if (digging)    return DIG;
    else if (walk_left)  return WALK_L;
    else if (walk_right) return WALK_R;
    else                 return IDLE;
  endfunction

endpackage

// File: rtl/lemmings_world_if.sv
// rtl/lemmings_world_if.sv - bundle between the lemming FSM side and the world model
// Signals: walk_left/walk_right/aaah/digging (behaviour in), cfg_we/cfg_x/
// cfg_y/cfg_solid (tile writes in), ground/bump_left/bump_right/lem_x/lem_y/
// splat (world state out). master drives behaviour and config, slave is the world.
interface lemmings_world_if #(
  parameter int W = 16,
  parameter int D = 8
);
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(D);

  logic          walk_left;
  logic          walk_right;
  logic          aaah;
  logic          digging;
  logic          cfg_we;
  logic [XW-1:0] cfg_x;
  logic [YW-1:0] cfg_y;
  logic          cfg_solid;
  logic          ground;
  logic          bump_left;
  logic          bump_right;
  logic [XW-1:0] lem_x;
  logic [YW-1:0] lem_y;
  logic          splat;

  modport master (
    output walk_left, walk_right, aaah, digging, cfg_we, cfg_x, cfg_y, cfg_solid,
    input  ground, bump_left, bump_right, lem_x, lem_y, splat
  );

  modport slave (
    input  walk_left, walk_right, aaah, digging, cfg_we, cfg_x, cfg_y, cfg_solid,
    output ground, bump_left, bump_right, lem_x, lem_y, splat
  );

endinterface

// File: rtl/lemmings_world_terrain.sv
// rtl/lemmings_world_terrain.sv - W x D tile map with bedrock bottom row
// Ports: clk, areset_n; we/wx/wy/wdata single write port (caller arbitrates);
// pos_x/pos_y lemming position; below_solid/left_solid/right_solid are
// combinational reads of (x,y+1), (x-1,y), (x+1,y). Off-map sides read empty.
module lemmings_terrain #(
  parameter int W = 16,
  parameter int D = 8
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 we,
  input  logic [$clog2(W)-1:0] wx,
  input  logic [$clog2(D)-1:0] wy,
  input  logic                 wdata,
  input  logic [$clog2(W)-1:0] pos_x,
  input  logic [$clog2(D)-1:0] pos_y,
  output logic                 below_solid,
  output logic                 left_solid,
  output logic                 right_solid
);
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(D);

  // Only rows 0..D-2 are stored; the bedrock row has no storage.
  logic [W-1:0] rows_q [0:D-2];

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int r = 0; r < D-1; r++) rows_q[r] <= '0;
    end else if (we && int'(wy) < D-1 && int'(wx) < W) begin
      rows_q[wy][wx] <= wdata;
    end
  end

  function automatic logic solid_at(input int x, input int y);
    if (y >= D-1)             return 1'b1;
    if (x < 0 || x >= W || y < 0) return 1'b0;
    return rows_q[YW'(y)][XW'(x)];
  endfunction

  always_comb begin
    below_solid = solid_at(int'(pos_x),     int'(pos_y) + 1);
    left_solid  = solid_at(int'(pos_x) - 1, int'(pos_y));
    right_solid = solid_at(int'(pos_x) + 1, int'(pos_y));
  end

endmodule

// File: rtl/lemmings_world.sv
// rtl/lemmings_world.sv - environment model closing the lemming FSM feedback loop
// Ports: clk, areset_n (async, active low); bus (slave) carries behaviour
// inputs, tile config writes, and the registered ground/bump/position/splat
// outputs. START_Y sets the row after reset (bedrock top by default).
module lemmings_world
  import lemmings_pkg::*;
#(
  parameter int W       = LEM_W,
  parameter int D       = LEM_D,
  parameter int START_X = 0,
  parameter int START_Y = D - 2,
  parameter int STEP    = LEM_STEP,
  parameter int DIG     = LEM_DIG,
  parameter int FATAL   = LEM_FATAL
) (
  input  logic             clk,
  input  logic             areset_n,
  lemmings_world_if.slave  bus
);
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(D);
  localparam int TW = $clog2(STEP);
  localparam int DW = $clog2(DIG + 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [7:0]    fall_q, fall_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          ground_q, ground_d;
  logic          bump_l_q, bump_l_d;
  logic          bump_r_q, bump_r_d;
  logic          splat_q, splat_d;

  behav_t        behav;
  logic          tick;
  logic          dig_clear;
  logic          cfg_ok;
  logic          t_we, t_wdata;
  logic [XW-1:0] t_wx;
  logic [YW-1:0] t_wy;
  logic          below_solid, left_solid, right_solid;

  lemmings_terrain #(.W(W), .D(D)) u_terrain (
    .clk         (clk),
    .areset_n    (areset_n),
    .we          (t_we),
    .wx          (t_wx),
    .wy          (t_wy),
    .wdata       (t_wdata),
    .pos_x       (x_q),
    .pos_y       (y_q),
    .below_solid (below_solid),
    .left_solid  (left_solid),
    .right_solid (right_solid)
  );

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      tick_q   <= '0;
      dig_q    <= '0;
      fall_q   <= '0;
      x_q      <= XW'(START_X);
      y_q      <= YW'(START_Y);
      ground_q <= 1'b1;
      bump_l_q <= 1'b0;
      bump_r_q <= 1'b0;
      splat_q  <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      dig_q    <= dig_d;
      fall_q   <= fall_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ground_q <= ground_d;
      bump_l_q <= bump_l_d;
      bump_r_q <= bump_r_d;
      splat_q  <= splat_d;
    end
  end

  always_comb begin
    behav     = decode_behav(bus.aaah, bus.digging, bus.walk_left, bus.walk_right);
    tick      = (tick_q == TW'(STEP - 1));
    tick_d    = tick ? '0 : tick_q + TW'(1);
    dig_d     = '0;
    fall_d    = fall_q;
    x_d       = x_q;
    y_d       = y_q;
    // ground samples the map/position as they stand this cycle, hence 1-cycle lag.
    ground_d  = below_solid;
    bump_l_d  = 1'b0;
    bump_r_d  = 1'b0;
    splat_d   = splat_q;
    dig_clear = 1'b0;

    case (behav)
      WALK_L: if (tick) begin
        if (x_q == '0 || left_solid) bump_l_d = 1'b1;
        else                         x_d = x_q - XW'(1);
      end
      WALK_R: if (tick) begin
        if (x_q == XW'(W - 1) || right_solid) bump_r_d = 1'b1;
        else                                  x_d = x_q + XW'(1);
      end
      FALL: if (tick && !below_solid) begin
        y_d = y_q + YW'(1);
        if (fall_q != 8'hFF) fall_d = fall_q + 8'd1;
      end
      lemmings_pkg::DIG: begin
        if (dig_q == DW'(DIG - 1)) begin
          // Bedrock below: stay armed at DIG-1 and never remove anything.
          if (int'(y_q) + 1 == D - 1) dig_d = dig_q;
          else                        dig_clear = 1'b1;
        end else begin
          dig_d = dig_q + DW'(1);
        end
      end
      default: ;
    endcase

    // Landing is judged on the raw aaah, whatever else the lemming does now.
    if (!bus.aaah && fall_q != 8'd0) begin
      splat_d = splat_q | (fall_q > 8'(FATAL));
      fall_d  = 8'd0;
    end

    cfg_ok = bus.cfg_we && int'(bus.cfg_y) != D - 1 && int'(bus.cfg_x) < W &&
             !(bus.cfg_x == x_q && bus.cfg_y == y_q);

    // Config wins the single write port; a colliding dig removal is dropped.
    t_we    = cfg_ok || dig_clear;
    t_wx    = cfg_ok ? bus.cfg_x : x_q;
    t_wy    = cfg_ok ? bus.cfg_y : y_q + YW'(1);
    t_wdata = cfg_ok ? bus.cfg_solid : 1'b0;
  end

  assign bus.ground     = ground_q;
  assign bus.bump_left  = bump_l_q;
  assign bus.bump_right = bump_r_q;
  assign bus.lem_x      = x_q;
  assign bus.lem_y      = y_q;
  assign bus.splat      = splat_q;

endmodule

// File: doc/lemmings_world.md
# lemmings_world

Environment model that drives the sensor inputs of the lemming behaviour FSM (`ground`, `bump_left`, `bump_right`) from that FSM's behaviour outputs (`walk_left`, `walk_right`, `aaah`, `digging`). It keeps a 2-D tile map and the lemming's position, and advances the position on a fixed move tick. Tiles are removed by digging. Sits beside the lemming FSM in the game top level and closes its feedback loop.

## Interface
- `W`, 16: level width in columns.
- `D`, 8: level depth in rows. Row 0 is the top. Row D-1 is bedrock: always solid, never diggable.
- `START_X`, 0: lemming column after reset.
- `STEP`, 4: cycles per move tick, ≥2.
- `DIG`, 8: consecutive digging cycles needed to remove one tile.
- `FATAL`, 4: a fall of more than FATAL rows is fatal.

Ports:
- `clk`  in  1  clock, rising edge.
- `areset_n`  in  1  asynchronous, active-low reset.
- `walk_left`, `walk_right`, `aaah`, `digging`  in  1 each  lemming FSM state outputs.
- `cfg_we`  in  1  tile write strobe.
- `cfg_x`  in  $clog2(W)  tile column.
- `cfg_y`  in  $clog2(D)  tile row.
- `cfg_solid`  in  1  tile value to write.
- `ground`  out  1  registered: tile at (x, y+1) is solid.
- `bump_left`, `bump_right`  out  1  registered one-cycle pulses.
- `lem_x`, `lem_y`  out  $clog2(W), $clog2(D)  current position.
- `splat`  out  1  sticky: a fatal fall has occurred.

## Operation
- Reset state:
  - Map cleared except the bedrock row.
  - Position (START_X, D-2).
  - `ground`=1; `bump_*`=0; `splat`=0.
  - Tick, dig and fall counters all 0.
- Tick counter runs 0..STEP-1 and wraps. Moves happen only on cycles with tick==STEP-1 (the tick cycle).
- Behaviour inputs are decoded with priority aaah > digging > walk_left > walk_right. All inputs zero means idle.
- Walk left, on tick cycle:
  - If x==0 or tile (x-1, y) is solid: pulse `bump_left`; x unchanged.
  - Otherwise x←x-1.
- Walk right: mirror of walk left, with limit W-1 and `bump_right`.
- Falling (`aaah`), on tick cycle:
  - If tile (x, y+1) is empty: y←y+1 and fall_cnt++ (saturating).
  - Otherwise no move.
- Landing: on the first cycle with `aaah`=0 after fall_cnt≠0:
  - If fall_cnt>FATAL, set `splat`.
  - Clear fall_cnt.
- Digging: dig_cnt increments every cycle `digging`=1, irrespective of tick.
  - When dig_cnt reaches DIG-1 and tile (x, y+1) is not bedrock: clear that tile and reset dig_cnt.
  - If the tile below is bedrock: dig_cnt holds at DIG-1 and nothing is removed.
  - dig_cnt clears whenever `digging`=0.
- Config writes:
  - A write to a bedrock tile is ignored.
  - A write to the tile the lemming occupies is ignored.
  - A write with cfg_solid=1 to the tile being dug takes priority over the dig removal in the same cycle. dig_cnt still resets.
- `splat` clears only on reset and does not freeze the world.

## Timing
- `ground`, `bump_*` and position are all registered.
- `ground` reflects the map and position as of the previous cycle: 1-cycle latency after a move, dig removal or cfg write.
- `bump_*` is high exactly one cycle: the cycle after the tick that blocked the walk.
- A dug tile appears as `ground`=0 one cycle after removal.
- Reset assertion mid-operation restores the full reset state immediately (asynchronous). The first tick occurs STEP cycles after deassertion.

## Structure
- Shared package `lemmings_pkg`:
  - Default W, D, STEP, DIG, FATAL.
  - Position typedefs.
  - Behaviour enum {IDLE, WALK_L, WALK_R, FALL, DIG}.
- Sub-module `lemmings_terrain`: W×D tile register array with:
  - One write port (cfg or dig clear, arbitrated by the caller).
  - Three combinational read ports: below, left, right.
  - Bedrock rows hard-wired solid.

## Test plan
- Reset, walk_left held, START_X=0: `bump_left` pulses once per tick (every 4 cycles); lem_x stays 0.
- START_X=0, walk_right held, cfg solid at (5,6): lem_x steps to 4, then `bump_right` pulses; lem_x stays 4.
- digging held at (3,6): after 8 cycles tile (3,7) stays solid (bedrock) and `ground` stays 1. Then cfg solid at (3,7)... repeat at y=5 over a loaded tile: the tile clears on cycle 8 and `ground`=0 on cycle 9.
- Lemming at y=0 over an empty column, aaah held: y advances 0→6 over 6 ticks, lands with fall_cnt=6, `splat`=1.
- Fall of 3 rows: `splat` stays 0. A cfg write to the dug tile in its removal cycle keeps the tile solid and `ground`=1.
- `areset_n` pulsed low mid-fall: position returns to (START_X, 6), `ground`=1, `splat`=0 immediately.
